// File: rtl/pwm_chaser_pkg.sv
`default_nettype none
// ============================================================================
// pwm_chaser_pkg : shared constants, types and helpers for pwm_chaser_fader
// Revision: 1.0
// ============================================================================
package pwm_chaser_pkg;

  localparam int DEFAULT_FADE_WIDTH = 4;

  // Entry k (LSB first) is the channel lit at sequence position k: 0,1,6,4,3,2,6,5
  localparam logic [23:0] DEFAULT_SEQ_FIG8 =
    {3'd5, 3'd6, 3'd2, 3'd3, 3'd4, 3'd6, 3'd1, 3'd0};

  typedef logic [DEFAULT_FADE_WIDTH-1:0] level_t;

  function automatic int ch_idx_w(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pwm_fade_channel.sv
`default_nettype none
// ============================================================================
// pwm_fade_channel : one LED channel - brightness level, tail decay, PWM compare
// Tail shape set by PWM_CHASER_LINEAR_FADE_EN (linear) or default (halving).
// Revision: 1.0
// ============================================================================
module pwm_fade_channel
  import pwm_chaser_pkg::*;
#(
  parameter int FADE_WIDTH = DEFAULT_FADE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  is_head,
  input  logic                  tail_en,
  input  logic                  fade_tick,
  input  logic [FADE_WIDTH-1:0] pwm_cnt,
  output logic                  led_on
);

  logic [FADE_WIDTH-1:0] level_q, level_d;
  logic                  led_on_q, led_on_d;

  always_comb begin
    led_on_d = (level_q > pwm_cnt);
    level_d  = level_q;
    if (is_head) begin
      level_d = '1;
    end else if (!tail_en) begin
      level_d = '0;
    end else if (fade_tick) begin
`ifdef PWM_CHASER_LINEAR_FADE_EN
      level_d = (level_q == '0) ? '0 : level_q - 1'b1;
`else
      level_d = level_q >> 1;
`endif
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q  <= '0;
      led_on_q <= 1'b0;
    end else begin
      level_q  <= level_d;
      led_on_q <= led_on_d;
    end
  end

  assign led_on = led_on_q;

endmodule
`default_nettype wire

// File: rtl/pwm_chaser_fader.sv
`default_nettype none
// ============================================================================
// pwm_chaser_fader : NUM_CH-channel LED chaser with PWM-faded tail
// Optional macro PWM_CHASER_LINEAR_FADE_EN selects a linear tail decay.
// Revision: 1.0
// ============================================================================
module pwm_chaser_fader
  import pwm_chaser_pkg::*;
#(
  parameter int                                NUM_CH         = 7,
  parameter int                                STEPS          = 8,
  parameter logic [STEPS*ch_idx_w(NUM_CH)-1:0] SEQ            = DEFAULT_SEQ_FIG8,
  parameter int                                FADE_WIDTH     = 4,
  parameter int                                STEP_DIV_WIDTH = 22,
  parameter int                                FADE_DIV_WIDTH = 18,
  parameter int                                COMMON_ANODE   = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     direction,
  input  logic                     tail_en,
  input  logic [2:0]               speed,
  output logic [NUM_CH-1:0]        led_out,
  output logic [$clog2(STEPS)-1:0] step_idx,
  output logic                     step_pulse
);

  localparam int               CH_W     = ch_idx_w(NUM_CH);
  localparam int               IDX_W    = $clog2(STEPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  logic                      enable_q, enable_d;
  logic                      direction_q, direction_d;
  logic                      tail_en_q, tail_en_d;
  logic [2:0]                speed_q, speed_d;
  logic [STEP_DIV_WIDTH-1:0] step_cnt_q, step_cnt_d, step_limit;
  logic [IDX_W-1:0]          step_idx_q, step_idx_d;
  logic                      step_pulse_q, step_pulse_d;
  logic [FADE_DIV_WIDTH-1:0] fade_cnt_q, fade_cnt_d;
  logic [FADE_WIDTH-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic                      step_tick, fade_tick;
  logic [CH_W-1:0]           head_ch;
  logic [NUM_CH-1:0]         led_on;

  always_comb begin
    enable_d    = enable;
    direction_d = direction;
    tail_en_d   = tail_en;
    speed_d     = speed;

    // Compare with >= so a speed drop below the running count still wraps.
    step_limit = {speed_q, {(STEP_DIV_WIDTH-3){1'b1}}};
    step_tick  = enable_q && (step_cnt_q >= step_limit);

    step_cnt_d = step_cnt_q;
    if (enable_q) begin
      step_cnt_d = step_tick ? '0 : step_cnt_q + 1'b1;
    end

    step_idx_d = step_idx_q;
    if (step_tick) begin
      if (direction_q) begin
        step_idx_d = (step_idx_q == LAST_IDX) ? '0 : step_idx_q + 1'b1;
      end else begin
        step_idx_d = (step_idx_q == '0) ? LAST_IDX : step_idx_q - 1'b1;
      end
    end
    step_pulse_d = step_tick;

    fade_tick  = &fade_cnt_q;
    fade_cnt_d = fade_cnt_q + 1'b1;
    pwm_cnt_d  = pwm_cnt_q + 1'b1;

    head_ch = SEQ[step_idx_q*CH_W +: CH_W];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      enable_q     <= 1'b0;
      direction_q  <= 1'b0;
      tail_en_q    <= 1'b0;
      speed_q      <= '0;
      step_cnt_q   <= '0;
      step_idx_q   <= '0;
      step_pulse_q <= 1'b0;
      fade_cnt_q   <= '0;
      pwm_cnt_q    <= '0;
    end else begin
      enable_q     <= enable_d;
      direction_q  <= direction_d;
      tail_en_q    <= tail_en_d;
      speed_q      <= speed_d;
      step_cnt_q   <= step_cnt_d;
      step_idx_q   <= step_idx_d;
      step_pulse_q <= step_pulse_d;
      fade_cnt_q   <= fade_cnt_d;
      pwm_cnt_q    <= pwm_cnt_d;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    pwm_fade_channel #(
      .FADE_WIDTH (FADE_WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .is_head   (head_ch == CH_W'(i)),
      .tail_en   (tail_en_q),
      .fade_tick (fade_tick),
      .pwm_cnt   (pwm_cnt_q),
      .led_on    (led_on[i])
    );
  end

  assign led_out    = (COMMON_ANODE != 0) ? ~led_on : led_on;
  assign step_idx   = step_idx_q;
  assign step_pulse = step_pulse_q;

endmodule
`default_nettype wire

// File: doc/pwm_chaser_fader.md
Name: pwm_chaser_fader

Overview:
- Parametrised successor to the 7-segment spinner: drives NUM_CH LED channels through a programmable STEPS-long channel sequence.
- Each channel has a FADE_WIDTH-bit brightness level rendered by a shared PWM counter.
- The head channel is lit at full level; channels it leaves decay as a fading tail.
- Sits directly behind the I/O pins in a TinyTapeout-style top; speed, direction, tail and enable come from pins.

Parameters:
- NUM_CH, 7: number of LED channels.
- STEPS, 8: sequence length.
- SEQ, {3'd5,3'd6,3'd2,3'd3,3'd4,3'd6,3'd1,3'd0}: packed STEPS x CH_IDX_W table; entry k = channel lit at position k. Default is the figure-8 0,1,6,4,3,2,6,5.
- FADE_WIDTH, 4: level and PWM counter width.
- STEP_DIV_WIDTH, 22: step prescaler width; must be >= 4.
- FADE_DIV_WIDTH, 18: fade prescaler width.
- COMMON_ANODE, 1: 1 inverts led_out.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = sequence advances.
- direction  in  1  1 = forward, 0 = reverse.
- tail_en  in  1  1 = fading tail, 0 = head only.
- speed  in  3  step period select.
- led_out  out  NUM_CH  PWM LED drive, polarity per COMMON_ANODE.
- step_idx  out  $clog2(STEPS)  current sequence position.
- step_pulse  out  1  one-cycle pulse when position changes.

Behaviour:
- Reset (async assert, sync release clears nothing extra):
  - all levels 0, led_on 0, so led_out = all-ones if COMMON_ANODE else all-zeros.
  - step_idx 0, step_pulse 0, all counters 0, input sample registers 0.
- Input sampling: enable, direction, tail_en, speed are registered once; all logic uses the sampled copies, so every input change takes effect 1 cycle later.
- Step prescaler:
  - limit = {speed_q, (STEP_DIV_WIDTH-3) ones}.
  - When enable_q: counter increments; at counter == limit it goes to 0 and step_tick fires.
  - When !enable_q: counter and step_idx hold.
  - Period = (speed+1)*2^(STEP_DIV_WIDTH-3) cycles.
  - A speed change mid-count applies to the current count. If counter > new limit, wrap at the next compare (counter >= limit).
- Position:
  - On step_tick, forward: idx==STEPS-1 goes to 0, otherwise +1. Reverse: idx==0 goes to STEPS-1, otherwise -1.
  - step_pulse is registered and high in the same cycle step_idx updates.
- Fade prescaler: free-running while out of reset, regardless of enable. fade_tick fires when the counter is all-ones; the counter then wraps to 0.
- Levels, per channel per cycle, in priority order:
  1. channel == SEQ[step_idx] (registered idx): level = all-ones.
  2. else if !tail_en_q: level = 0.
  3. else if fade_tick: level = level >> 1.
  4. else hold.
  - The new head is loaded 1 cycle after step_pulse.
  - A channel appearing twice in SEQ is reloaded on each visit.
- PWM:
  - pwm_cnt is FADE_WIDTH bits, increments every cycle and wraps.
  - led_on[i] <= (level[i] > pwm_cnt), registered.
  - Duty = level / 2^FADE_WIDTH; level 0 is never on.
- Output: led_out = COMMON_ANODE ? ~led_on : led_on.

Optional Feature:
- Macro PWM_CHASER_LINEAR_FADE_EN.
- Defined: on fade_tick, non-head levels decrement by 1, saturating at 0 (linear tail, 2^FADE_WIDTH-1 ticks long).
- Undefined: right-shift by 1 (exponential tail, FADE_WIDTH ticks long).
- All other behaviour is identical.

Decomposition:
- Package pwm_chaser_pkg holds:
  - DEFAULT_SEQ_FIG8 constant.
  - CH_IDX_W = $clog2(NUM_CH) helper.
  - level_t typedef.
- Sub-module pwm_fade_channel, instantiated NUM_CH times:
  - inputs: is_head, tail_en, fade_tick, pwm_cnt.
  - contents: one level register, next-level logic including the macro choice, comparator, led_on flop.

Test Plan (STEP_DIV_WIDTH=6, FADE_DIV_WIDTH=4, FADE_WIDTH=4, defaults otherwise):
1. Async reset: assert reset=0 mid-cycle -> led_out=7'h7F immediately, step_idx=0. Release -> level[0]=15 within 2 cycles.
2. enable=1, direction=1, speed=0 -> step_pulse every 8 cycles; step_idx 0..7 then 0; head channel sequence 0,1,6,4,3,2,6,5.
3. direction=0 from step_idx=0 -> next step_idx=7 (head ch5); speed=3 -> pulse every 32 cycles.
4. tail_en=1 -> after ch0 leaves head, level goes 15,7,3,1,0 at fade ticks 16 cycles apart (LINEAR: 15,14,...,0). tail_en=0 -> non-head levels 0 two cycles later.
5. PWM duty: hold head on ch0 with enable=0 -> led_on[0] high 15 of every 16 cycles. A channel at level 1 -> high 1 of 16.
6. enable=0 for 100 cycles -> step_idx and step prescaler frozen, no step_pulse, fade continues. Re-enable -> first pulse after the remaining count.
